// File: rtl/rv_dmem_responder.sv
// rv_dmem_responder: data-memory target for the RV32I load/store port.
// Takes one request at a time, performs the access LATENCY cycles after
// acceptance and holds the response until the requester takes it.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_we, req_addr,        store flag, byte address, right-aligned store
//   req_wdata, req_funct3    data, RV32I size/sign code
//   resp_valid / resp_ready  response handshake
//   resp_rdata, resp_err     extended load data (0 for stores/errors), fault
//
// Build option: define DMEM_MISALIGN_CHECK_EN to fault misaligned halfword
// and word accesses; otherwise they are aligned down and complete normally.
//
// state  | meaning
// S_IDLE | waiting for a request, req_ready high
// S_WAIT | request latched, latency counter running down
// S_RESP | response registered, held until resp_ready

module rv_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [33:0] ADDR_LIMIT = 34'(DEPTH_WORDS) * 34'd4;
  localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] word_idx;
  logic        fire;
  logic        misalign;
  logic        acc_err;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] wr_word;
  logic [3:0]  wr_be;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The access happens on the edge that leaves WAIT.
  assign fire     = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign word_idx = addr_q[IDX_W+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                    ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Illegal codes 011/110/111, unsigned sizes used as stores, out of range.
  assign acc_err = ({2'b00, addr_q} >= ADDR_LIMIT) ||
                   (f3_q[1:0] == 2'b11) || (f3_q[2] && f3_q[1]) ||
                   (we_q && f3_q[2]) || misalign;

  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
  assign rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = 32'd0;
    case (f3_q)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'd0, rd_byte};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = 32'd0;
    endcase
  end

  always_comb begin
    wr_word = wdata_q;
    wr_be   = 4'b1111;
    case (f3_q[1:0])
      2'b00: begin
        wr_word = {4{wdata_q[7:0]}};
        wr_be   = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        wr_word = {2{wdata_q[15:0]}};
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wr_word = wdata_q;
        wr_be   = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fire) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || we_q) ? 32'd0 : load_val;
      end
    end
  end

  // Request fields are captured only at acceptance.
  always_ff @(posedge clk) begin
    if (!reset && req_valid && req_ready) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      f3_q    <= req_funct3;
    end
  end

  // Storage is never reset; a reset on the commit edge aborts the store.
  always_ff @(posedge clk) begin
    if (!reset && fire && we_q && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

endmodule
